// File: rtl/mps_pkg.sv
// mps_pkg: shared widths, instruction field positions and opcode
// enumeration for the MPS single-cycle core.
package mps_pkg;

  localparam int PC_W      = 8;
  localparam int DATA_W    = 8;
  localparam int INSN_W    = 16;
  localparam int REG_COUNT = 16;
  localparam int REG_AW    = $clog2(REG_COUNT);

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_JMP  = 4'hA,
    OP_BZ   = 4'hB,
    OP_BNZ  = 4'hC,
    OP_ADDI = 4'hD,
    OP_MOV  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

endpackage

// File: rtl/mps_regfile.sv
// mps_regfile: 16 x 8-bit register file.
// Ports:
//   clock_i       system clock
//   reset_i       synchronous active-high clear of all registers
//   we_i          write enable
//   waddr_i       write address
//   wdata_i       write data
//   raddr_rs_i/rt_i/rd_i   asynchronous read addresses
//   rdata_rs_o/rt_o/rd_o   asynchronous read data (pre-edge values)
module mps_regfile
  import mps_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_rs_i,
  input  logic [REG_AW-1:0] raddr_rt_i,
  input  logic [REG_AW-1:0] raddr_rd_i,
  output logic [DATA_W-1:0] rdata_rs_o,
  output logic [DATA_W-1:0] rdata_rt_o,
  output logic [DATA_W-1:0] rdata_rd_o
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_rs_o = regs_q[raddr_rs_i];
  assign rdata_rt_o = regs_q[raddr_rt_i];
  assign rdata_rd_o = regs_q[raddr_rd_i];

endmodule

// File: rtl/mps_cpu.sv
// mps_cpu: single-cycle 8-bit core, 16-bit instructions, Harvard ports.
// Ports:
//   clock         system clock
//   reset         synchronous active-high; clears PC, halt and registers
//   imem_addr     current PC
//   imem_value    instruction at imem_addr (combinational)
//   dmem_addr     rs value for LD/ST, else 0
//   dmem_wenable  high for the whole cycle of an executing ST
//   dmem_rvalue   data at dmem_addr (combinational)
//   dmem_wvalue   rd value for ST, else 0
module mps_cpu
  import mps_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_value,
  output logic [PC_W-1:0]   dmem_addr,
  output logic              dmem_wenable,
  input  logic [DATA_W-1:0] dmem_rvalue,
  output logic [DATA_W-1:0] dmem_wvalue
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;

  opcode_e           op;
  logic [REG_AW-1:0] rd_a, rs_a, rt_a;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rd_v, rs_v, rt_v;

  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic              exec;

  assign op   = opcode_e'(imem_value[OP_MSB:OP_LSB]);
  assign rd_a = imem_value[RD_MSB:RD_LSB];
  assign rs_a = imem_value[RS_MSB:RS_LSB];
  assign rt_a = imem_value[RT_MSB:RT_LSB];
  assign imm  = imem_value[IMM_MSB:IMM_LSB];

  mps_regfile u_regfile (
    .clock_i    (clock),
    .reset_i    (reset),
    .we_i       (wb_en),
    .waddr_i    (rd_a),
    .wdata_i    (wb_data),
    .raddr_rs_i (rs_a),
    .raddr_rt_i (rt_a),
    .raddr_rd_i (rd_a),
    .rdata_rs_o (rs_v),
    .rdata_rt_o (rt_v),
    .rdata_rd_o (rd_v)
  );

  // Decode, ALU and next-PC. Once halted, nothing but reset moves the core,
  // even if the instruction memory contents change underneath it.
  always_comb begin
    wb_en    = 1'b0;
    wb_data  = '0;
    pc_d     = pc_q + 8'd1;
    halted_d = halted_q;
    if (halted_q) begin
      pc_d = pc_q;
    end else begin
      case (op)
        OP_LDI:  begin wb_en = 1'b1; wb_data = imm;            end
        OP_ADD:  begin wb_en = 1'b1; wb_data = rs_v + rt_v;    end
        OP_SUB:  begin wb_en = 1'b1; wb_data = rs_v - rt_v;    end
        OP_AND:  begin wb_en = 1'b1; wb_data = rs_v & rt_v;    end
        OP_OR:   begin wb_en = 1'b1; wb_data = rs_v | rt_v;    end
        OP_XOR:  begin wb_en = 1'b1; wb_data = rs_v ^ rt_v;    end
        OP_SHR:  begin wb_en = 1'b1; wb_data = rs_v >> 1;      end
        OP_LD:   begin wb_en = 1'b1; wb_data = dmem_rvalue;    end
        OP_ADDI: begin wb_en = 1'b1; wb_data = rd_v + imm;     end
        OP_MOV:  begin wb_en = 1'b1; wb_data = rs_v;           end
        OP_JMP:  pc_d = imm;
        OP_BZ:   if (rd_v == '0) pc_d = imm;
        OP_BNZ:  if (rd_v != '0) pc_d = imm;
        OP_HALT: begin pc_d = pc_q; halted_d = 1'b1;           end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Memory-side outputs depend only on registered state, imem_value and
  // reset; reset gating makes a ST in the reset cycle invisible immediately.
  assign exec         = !reset && !halted_q;
  assign dmem_wenable = exec && (op == OP_ST);
  assign dmem_addr    = (exec && (op == OP_LD || op == OP_ST)) ? rs_v : '0;
  assign dmem_wvalue  = dmem_wenable ? rd_v : '0;
  assign imem_addr    = pc_q;

endmodule

// File: tb/tb_mps_cpu.sv
module tb_mps_cpu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_value;
  logic [7:0]  dmem_addr;
  logic        dmem_wenable;
  logic [7:0]  dmem_rvalue;
  logic [7:0]  dmem_wvalue;

  logic [15:0] imem    [256];
  logic [7:0]  ext_mem [256];

  // behavioural reference state
  logic [7:0]  m_pc;
  logic [7:0]  m_r   [16];
  logic [7:0]  m_mem [256];
  bit          m_halt;

  logic [15:0] st_log [$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  assign imem_value  = imem[imem_addr];
  assign dmem_rvalue = ext_mem[dmem_addr];

  always @(posedge clock) begin
    if (dmem_wenable === 1'b1) begin
      ext_mem[dmem_addr] <= dmem_wvalue;
      st_log.push_back({dmem_addr, dmem_wvalue});
    end
  end

  mps_cpu dut (
    .clock        (clock),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_value   (imem_value),
    .dmem_addr    (dmem_addr),
    .dmem_wenable (dmem_wenable),
    .dmem_rvalue  (dmem_rvalue),
    .dmem_wvalue  (dmem_wvalue)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] log_at(input int idx);
    if (idx < st_log.size()) return st_log[idx];
    return 16'hDEAD;
  endfunction

  // One clock cycle: compare DUT outputs to the model at the falling edge,
  // advance the model, then return just after the rising edge.
  task automatic step();
    logic [15:0] w;
    logic [3:0]  op, rd, rs, rt;
    logic [7:0]  imm, e_addr, e_wv, nxt;
    logic        e_we;
    @(negedge clock);
    w   = imem[m_pc];
    op  = w[15:12];
    rd  = w[11:8];
    rs  = w[7:4];
    rt  = w[3:0];
    imm = w[7:0];
    e_we = 1'b0; e_addr = 8'h00; e_wv = 8'h00;
    if (!reset && !m_halt && (op == 4'h8 || op == 4'h9)) e_addr = m_r[rs];
    if (!reset && !m_halt && op == 4'h9) begin
      e_we = 1'b1;
      e_wv = m_r[rd];
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("dmem_wenable", dmem_wenable, e_we);
    chk("dmem_addr", dmem_addr, e_addr);
    chk("dmem_wvalue", dmem_wvalue, e_wv);
    if (reset) begin
      m_pc   = 8'h00;
      m_halt = 1'b0;
      foreach (m_r[i]) m_r[i] = 8'h00;
    end else if (!m_halt) begin
      nxt = m_pc + 8'd1;
      case (op)
        4'h1: m_r[rd] = imm;
        4'h2: m_r[rd] = m_r[rs] + m_r[rt];
        4'h3: m_r[rd] = m_r[rs] - m_r[rt];
        4'h4: m_r[rd] = m_r[rs] & m_r[rt];
        4'h5: m_r[rd] = m_r[rs] | m_r[rt];
        4'h6: m_r[rd] = m_r[rs] ^ m_r[rt];
        4'h7: m_r[rd] = m_r[rs] / 2;
        4'h8: m_r[rd] = m_mem[m_r[rs]];
        4'h9: m_mem[m_r[rs]] = m_r[rd];
        4'hA: nxt = imm;
        4'hB: if (m_r[rd] == 8'h00) nxt = imm;
        4'hC: if (m_r[rd] != 8'h00) nxt = imm;
        4'hD: m_r[rd] = m_r[rd] + imm;
        4'hE: m_r[rd] = m_r[rs];
        4'hF: begin nxt = m_pc; m_halt = 1'b1; end
        default: ;
      endcase
      m_pc = nxt;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_imem();
    foreach (imem[i]) imem[i] = 16'h0000;
  endtask

  task automatic reset_run(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    foreach (ext_mem[i]) begin ext_mem[i] = 8'h00; m_mem[i] = 8'h00; end
    foreach (m_r[i]) m_r[i] = 8'h00;
    m_pc = 8'h00; m_halt = 1'b0;
    clear_imem();
    @(posedge clock); #1;

    // Reset and sequential PC with wrap
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_pc", imem_addr, 0);
      chk("rst_we", dmem_wenable, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("seq_pc", imem_addr, i);
      step();
    end
    repeat (252) step();
    chk("pc_ff", imem_addr, 8'hFF);
    step();
    chk("pc_wrap", imem_addr, 8'h00);

    // ALU
    clear_imem();
    imem[0] = 16'h1105; imem[1] = 16'h1203; imem[2] = 16'h2312;
    imem[3] = 16'h3421; imem[4] = 16'h9300; imem[5] = 16'h9400;
    imem[6] = 16'hF000;
    reset_run(1);
    st_log.delete();
    repeat (7) step();
    chk("alu_nst", st_log.size(), 2);
    chk("alu_add", log_at(0), 16'h0008);
    chk("alu_sub", log_at(1), 16'h00FE);

    // Memory
    clear_imem();
    imem[0] = 16'h1540; imem[1] = 16'h16A5; imem[2] = 16'h9650;
    imem[3] = 16'h8750; imem[4] = 16'h9700; imem[5] = 16'hF000;
    reset_run(1);
    st_log.delete();
    repeat (6) step();
    chk("mem_nst", st_log.size(), 2);
    chk("mem_st", log_at(0), 16'h40A5);
    chk("mem_ld", log_at(1), 16'h00A5);

    // Branches
    clear_imem();
    imem[8'h00] = 16'h1100; imem[8'h01] = 16'hB110;
    imem[8'h10] = 16'hC120; imem[8'h11] = 16'hA005;
    imem[8'h05] = 16'hF000;
    reset_run(1);
    step(); step();
    chk("bz_taken", imem_addr, 8'h10);
    step();
    chk("bnz_fall", imem_addr, 8'h11);
    step();
    chk("jmp", imem_addr, 8'h05);

    // Add wrap, then halt
    clear_imem();
    imem[0] = 16'h11FF; imem[1] = 16'hD102; imem[2] = 16'h9100; imem[3] = 16'hF000;
    reset_run(1);
    st_log.delete();
    repeat (3) step();
    chk("addi_wrap", log_at(0), 16'h0001);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_pc", imem_addr, 8'h03);
      chk("halt_we", dmem_wenable, 0);
    end

    // Reset during a ST
    clear_imem();
    imem[0] = 16'h1377; imem[1] = 16'h1412; imem[2] = 16'h9340; imem[3] = 16'hF000;
    reset_run(1);
    step(); step();
    chk("mid_pre_we", dmem_wenable, 1);
    reset = 1'b1;
    #1;
    chk("mid_we", dmem_wenable, 0);
    chk("mid_addr", dmem_addr, 0);
    st_log.delete();
    step();
    chk("mid_pc", imem_addr, 0);
    chk("mid_nostore", st_log.size(), 0);
    clear_imem();
    imem[0] = 16'h9300; imem[1] = 16'h9410; imem[2] = 16'h9F00; imem[3] = 16'hF000;
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("clr_r3", log_at(0), 16'h0000);
    chk("clr_r4", log_at(1), 16'h0000);
    chk("clr_r15", log_at(2), 16'h0000);

    // Randomized programs against the reference model
    for (int round = 0; round < 20; round++) begin
      int diffs;
      for (int i = 0; i < 256; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h0;
        imem[i] = w;
        ext_mem[i] = 8'($urandom);
        m_mem[i] = ext_mem[i];
      end
      reset_run(1);
      for (int c = 0; c < 200; c++) begin
        reset = ($urandom_range(0, 99) == 0);
        step();
      end
      reset = 1'b0;
      diffs = 0;
      for (int i = 0; i < 256; i++) if (ext_mem[i] !== m_mem[i]) diffs++;
      chk("mem_image", diffs, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
